wb_byte_sequencer: RTL and testbench

//  Multi-cycle Wishbone width adapter: 32-bit master port to 8-bit slave port.

---
 rtl/wb_byte_sequencer.sv | 151 +++++++++++++++
 tb/tb_wb_byte_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_byte_sequencer.sv
// 32-bit to 8-bit Wishbone adapter: one slave access per set sel bit, sel[3] first; ack n+1 cycles after request.
// Slave wait states stretch ACCESS indefinitely; master dropping cyc aborts without a response.
module wb_byte_sequencer #(
    parameter int aw = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [aw-1:0] wbm_adr_i,
    input  logic [31:0]   wbm_dat_i,
    input  logic [3:0]    wbm_sel_i,
    input  logic          wbm_we_i,
    input  logic          wbm_cyc_i,
    input  logic          wbm_stb_i,
    input  logic [2:0]    wbm_cti_i,
    input  logic [1:0]    wbm_bte_i,
    output logic [31:0]   wbm_dat_o,
    output logic          wbm_ack_o,
    output logic          wbm_err_o,
    output logic          wbm_rty_o,
    output logic [aw-1:0] wbs_adr_o,
    output logic [7:0]    wbs_dat_o,
    output logic          wbs_we_o,
    output logic          wbs_cyc_o,
    output logic          wbs_stb_o,
    output logic [2:0]    wbs_cti_o,
    output logic [1:0]    wbs_bte_o,
    input  logic [7:0]    wbs_dat_i,
    input  logic          wbs_ack_i,
    input  logic          wbs_err_i,
    input  logic          wbs_rty_i
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    typedef enum logic [1:0] {R_ACK, R_ERR, R_RTY} resp_t;

    state_t        r_state;
    state_t        w_next;
    resp_t         r_resp;
    logic [aw-3:0] r_adr;
    logic [31:0]   r_dat;
    logic [31:0]   r_rdat;
    logic          r_we;
    logic [3:0]    r_mask;

    logic [1:0]    w_idx;
    logic [1:0]    w_off;
    logic [3:0]    w_lane;
    logic          w_req;
    logic          w_unused;

    assign w_unused = ^{wbm_adr_i[1:0], wbm_cti_i, wbm_bte_i};
    assign w_req    = wbm_cyc_i && wbm_stb_i;

    // Current lane is the highest remaining sel bit; sel[3] maps to byte offset 0.
    always_comb begin
        w_idx = 2'd0;
        w_off = 2'd0;
        if (r_mask[3]) begin
            w_idx = 2'd3;
            w_off = 2'd0;
        end else if (r_mask[2]) begin
            w_idx = 2'd2;
            w_off = 2'd1;
        end else if (r_mask[1]) begin
            w_idx = 2'd1;
            w_off = 2'd2;
        end else if (r_mask[0]) begin
            w_idx = 2'd0;
            w_off = 2'd3;
        end
    end

    assign w_lane = 4'b0001 << w_idx;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) w_next = (wbm_sel_i == 4'b0000) ? S_DONE : S_ACCESS;
            end
            S_ACCESS: begin
                if (!wbm_cyc_i)                   w_next = S_IDLE;
                else if (wbs_err_i || wbs_rty_i)  w_next = S_DONE;
                else if (wbs_ack_i && ((r_mask & ~w_lane) == 4'b0000))
                                                  w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_adr  <= '0;
            r_dat  <= '0;
            r_rdat <= '0;
            r_we   <= 1'b0;
            r_mask <= 4'b0000;
            r_resp <= R_ACK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_adr  <= wbm_adr_i[aw-1:2];
                        r_dat  <= wbm_dat_i;
                        r_we   <= wbm_we_i;
                        r_mask <= wbm_sel_i;
                        r_rdat <= '0;
                        r_resp <= R_ACK;
                    end
                end
                S_ACCESS: begin
                    if (wbm_cyc_i) begin
                        // err outranks rty outranks ack; remaining lanes are dropped
                        if (wbs_err_i) begin
                            r_resp <= R_ERR;
                            r_mask <= 4'b0000;
                        end else if (wbs_rty_i) begin
                            r_resp <= R_RTY;
                            r_mask <= 4'b0000;
                        end else if (wbs_ack_i) begin
                            r_mask <= r_mask & ~w_lane;
                            if (!r_we) r_rdat[{w_idx, 3'b000} +: 8] <= wbs_dat_i;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wbm_dat_o = r_rdat;
    assign wbm_ack_o = (r_state == S_DONE) && (r_resp == R_ACK);
    assign wbm_err_o = (r_state == S_DONE) && (r_resp == R_ERR);
    assign wbm_rty_o = (r_state == S_DONE) && (r_resp == R_RTY);

    assign wbs_cyc_o = (r_state == S_ACCESS);
    assign wbs_stb_o = (r_state == S_ACCESS);
    assign wbs_adr_o = {r_adr, w_off};
    assign wbs_dat_o = r_dat[{w_idx, 3'b000} +: 8];
    assign wbs_we_o  = r_we;
    assign wbs_cti_o = 3'b000;
    assign wbs_bte_o = 2'b00;

endmodule

// File: tb/tb_wb_byte_sequencer.sv
// Bench for wb_byte_sequencer: directed master requests, a wait/err/rty-configurable byte slave,
// and queues of expected slave accesses and master responses.
module tb_wb_byte_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wbm_adr_i, wbm_dat_i, wbm_dat_o;
    logic [3:0]  wbm_sel_i;
    logic        wbm_we_i, wbm_cyc_i, wbm_stb_i;
    logic [2:0]  wbm_cti_i;
    logic [1:0]  wbm_bte_i;
    logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [31:0] wbs_adr_o;
    logic [7:0]  wbs_dat_o, wbs_dat_i;
    logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]  wbs_cti_o;
    logic [1:0]  wbs_bte_o;
    logic        wbs_ack_i, wbs_err_i, wbs_rty_i;

    always #5 clk = ~clk;

    wb_byte_sequencer #(.aw(32)) dut (
        .wb_clk_i (clk),       .wb_rst_i (rst),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
        .wbm_we_i (wbm_we_i),  .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
        .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_we_o (wbs_we_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o),
        .wbs_bte_o(wbs_bte_o), .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i),
        .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i)
    );

    typedef struct { logic [31:0] adr; logic we; logic [7:0] dat; } sacc_t;
    typedef struct { int kind; logic [31:0] dat; int lat; } mresp_t;

    sacc_t  exp_acc[$];
    mresp_t exp_resp[$];

    int checks = 0;
    int errors = 0;

    int waits  = 0;
    int err_at = 0;
    int rty_at = 0;
    int acc_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [1:0] off);
        logic [7:0] o;
        o = {6'b0, off};
        return 8'hAA + 8'h11 * o;
    endfunction

    // Byte slave: checks each new access against the expected queue, then answers after 'waits' cycles.
    bit          busy = 1'b0;
    int          wc = 0;
    logic [31:0] cur_adr;
    always @(negedge clk) begin
        wbs_ack_i = 1'b0;
        wbs_err_i = 1'b0;
        wbs_rty_i = 1'b0;
        wbs_dat_i = 8'h00;
        if (wbs_cyc_o && wbs_stb_o) begin
            if (!busy) begin
                sacc_t e;
                busy = 1'b1;
                wc = 0;
                acc_cnt++;
                cur_adr = wbs_adr_o;
                if (exp_acc.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_access: observed adr 0x%08h expected no access", wbs_adr_o);
                end else begin
                    e = exp_acc.pop_front();
                    check("slave_adr", wbs_adr_o, e.adr);
                    check("slave_we", {31'b0, wbs_we_o}, {31'b0, e.we});
                    if (e.we) check("slave_wdat", {24'b0, wbs_dat_o}, {24'b0, e.dat});
                end
            end else begin
                check("stb_steady_adr", wbs_adr_o, cur_adr);
            end
            if (wc == waits) begin
                if (acc_cnt == err_at)      wbs_err_i = 1'b1;
                else if (acc_cnt == rty_at) wbs_rty_i = 1'b1;
                else                        wbs_ack_i = 1'b1;
                if (!wbs_we_o) wbs_dat_i = rd_byte(wbs_adr_o[1:0]);
                busy = 1'b0;
            end else begin
                wc++;
            end
        end else begin
            busy = 1'b0;
        end
    end

    // kind: 0 ack, 1 err, 2 rty. Called at a negedge; returns at the negedge after the response.
    task automatic do_req(input logic [31:0] adr, input logic [3:0] sel, input logic we,
                          input logic [31:0] dat, input int w, input int e_at, input int r_at,
                          input int kind, input int lat);
        int          n;
        int          k;
        int          obs_kind;
        bit          seen;
        bit          stop;
        logic [31:0] rexp;
        mresp_t      m;
        mresp_t      got;
        n = 0;
        stop = 1'b0;
        rexp = 32'h0;
        for (int i = 3; i >= 0; i--) begin
            if (sel[i] && !stop) begin
                sacc_t s;
                logic [1:0] off;
                n++;
                off = 2'(3 - i);
                s.adr = {adr[31:2], off};
                s.we  = we;
                s.dat = dat[8*i +: 8];
                exp_acc.push_back(s);
                if (n == e_at || n == r_at) stop = 1'b1;
                else if (!we) rexp[8*i +: 8] = rd_byte(off);
            end
        end
        m.kind = kind;
        m.dat  = rexp;
        m.lat  = lat;
        exp_resp.push_back(m);

        waits = w; err_at = e_at; rty_at = r_at; acc_cnt = 0;
        wbm_adr_i = adr; wbm_sel_i = sel; wbm_we_i = we; wbm_dat_i = dat;
        wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;

        seen = 1'b0;
        k = 0;
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(negedge clk);
            k = c;
            if (wbm_ack_o || wbm_err_o || wbm_rty_o) seen = 1'b1;
        end
        got = exp_resp.pop_front();
        if (!seen) begin
            checks++;
            errors++;
            $error("FAIL response_timeout: observed no response in 200 cycles expected kind %0d", got.kind);
        end else begin
            obs_kind = wbm_ack_o ? 0 : (wbm_err_o ? 1 : 2);
            check("resp_onehot", 32'(wbm_ack_o) + 32'(wbm_err_o) + 32'(wbm_rty_o), 32'd1);
            check("resp_kind", obs_kind, got.kind);
            check("resp_latency", k, got.lat);
            if (got.kind == 0) check("resp_dat", wbm_dat_o, got.dat);
        end
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        @(negedge clk);
        check("single_pulse", {29'b0, wbm_ack_o, wbm_err_o, wbm_rty_o}, 32'd0);
        check("idle_no_cyc", {31'b0, wbs_cyc_o}, 32'd0);
        check("acc_queue_drained", exp_acc.size(), 32'd0);
        err_at = 0; rty_at = 0; waits = 0;
    endtask

    initial begin
        int pulses;
        rst = 1'b1;
        wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = 1'b0;
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_cti_i = 3'b111; wbm_bte_i = 2'b11;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {26'b0, wbm_ack_o, wbm_err_o, wbm_rty_o, wbs_cyc_o, wbs_stb_o, wbs_we_o}, 32'd0);
        check("rst_wbm_dat", wbm_dat_o, 32'd0);
        check("rst_wbs_adr", wbs_adr_o, 32'd0);
        check("rst_wbs_misc", {19'b0, wbs_dat_o, wbs_cti_o, wbs_bte_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full-word read, zero-wait slave
        do_req(32'h0000_0100, 4'b1111, 1'b0, 32'h0, 0, 0, 0, 0, 5);
        // Sparse write
        do_req(32'h0000_0100, 4'b0101, 1'b1, 32'h1122_3344, 0, 0, 0, 0, 3);
        // Empty select: no slave access
        do_req(32'h0000_0104, 4'b0000, 1'b0, 32'h0, 0, 0, 0, 0, 1);
        // Error on second byte; lower lanes never issued
        do_req(32'h0000_0208, 4'b1100, 1'b0, 32'h0, 0, 2, 0, 1, 3);
        // Retry on first byte
        do_req(32'h0000_020C, 4'b0010, 1'b0, 32'h0, 0, 0, 1, 2, 2);
        // Three wait states per byte
        do_req(32'h0000_0500, 4'b0011, 1'b0, 32'h0, 3, 0, 0, 0, 9);

        // Reset during ACCESS
        begin
            sacc_t s;
            s.adr = 32'h0000_0200; s.we = 1'b0; s.dat = 8'h00;
            exp_acc.push_back(s);
        end
        waits = 3; acc_cnt = 0;
        wbm_adr_i = 32'h0000_0200; wbm_sel_i = 4'b1111; wbm_we_i = 1'b0;
        wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_cyc", {31'b0, wbs_cyc_o}, 32'd0);
        check("rst_mid_dat", wbm_dat_o, 32'd0);
        rst = 1'b0; wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(wbm_ack_o) + int'(wbm_err_o) + int'(wbm_rty_o);
        end
        check("rst_abort_no_pulse", pulses, 32'd0);
        check("rst_abort_queue", exp_acc.size(), 32'd0);

        // Master drops cyc during ACCESS
        begin
            sacc_t s;
            s.adr = 32'h0000_0300; s.we = 1'b1; s.dat = 8'hDE;
            exp_acc.push_back(s);
        end
        waits = 3; acc_cnt = 0;
        wbm_adr_i = 32'h0000_0300; wbm_sel_i = 4'b1001; wbm_we_i = 1'b1;
        wbm_dat_i = 32'hDEAD_BEEF; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        repeat (2) @(negedge clk);
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        @(negedge clk);
        check("cyc_drop_wbs_cyc", {31'b0, wbs_cyc_o}, 32'd0);
        pulses = int'(wbm_ack_o) + int'(wbm_err_o) + int'(wbm_rty_o);
        repeat (3) begin
            @(negedge clk);
            pulses += int'(wbm_ack_o) + int'(wbm_err_o) + int'(wbm_rty_o);
        end
        check("cyc_drop_no_pulse", pulses, 32'd0);
        check("cyc_drop_queue", exp_acc.size(), 32'd0);

        // Normal service after both aborts
        do_req(32'h0000_0400, 4'b1000, 1'b1, 32'h5A00_0000, 0, 0, 0, 0, 2);
        do_req(32'h0000_0404, 4'b0110, 1'b0, 32'h0, 1, 0, 0, 0, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
